// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues LB/LBU/LW/SB/SW/LL/SC on a single-beat bus and presents writeback results.
// Latency: non-memory ops pass through combinationally; memory ops take IDLE -> WAIT (until ack/timeout) -> DONE, min 3 cycles.
// Backpressure: stall_o holds upstream while a bus access is being entered or awaited; bus_ack_i is the only downstream flow control.
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              we_hilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       sdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              we_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              we_hilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              stall_o,
    output logic              excpt_o
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LB   = 3'd1;
    localparam logic [2:0] OP_LBU  = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SB   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_LL   = 3'd6;
    localparam logic [2:0] OP_SC   = 3'd7;

    // Last counter value seen in WAIT before the wait is declared expired.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_cnt;
    logic               r_llbit;
    logic               r_timeout;
    logic [31:0]        r_rdata;
    logic               r_bus_we;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [3:0]         r_bus_be;
    logic [31:0]        r_bus_wdata;

    logic               w_is_mem;
    logic               w_misalign;
    logic               w_sc_fail;
    logic               w_start;
    logic               w_expire;
    logic [7:0]         w_byte;

    assign w_is_mem   = (op_i != OP_NONE);
    assign w_misalign = ((op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_LL) || (op_i == OP_SC))
                        && (addr_i[1:0] != 2'b00);
    assign w_sc_fail  = (op_i == OP_SC) && !r_llbit;
    assign w_start    = (r_state == S_IDLE) && w_is_mem && !w_misalign && !w_sc_fail;
    assign w_expire   = !bus_ack_i && (r_cnt == LP_CNT_LAST);

    // Big-endian lane pick from the word captured at ack: lane 0 is the MSB.
    always_comb begin
        w_byte = r_rdata[7:0];
        case (addr_i[1:0])
            2'd0:    w_byte = r_rdata[31:24];
            2'd1:    w_byte = r_rdata[23:16];
            2'd2:    w_byte = r_rdata[15:8];
            default: w_byte = r_rdata[7:0];
        endcase
    end

    // State, wait counter, bus command latch, read capture and LL reservation bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_llbit     <= 1'b0;
            r_timeout   <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_cnt       <= 8'd0;
                r_timeout   <= 1'b0;
                r_bus_we    <= (op_i == OP_SB) || (op_i == OP_SW) || (op_i == OP_SC);
                r_bus_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
                r_bus_be    <= (op_i == OP_SB) ? (4'b1000 >> addr_i[1:0]) : 4'b1111;
                r_bus_wdata <= (op_i == OP_SB) ? {4{sdata_i[7:0]}} : sdata_i;
            end
            if (r_state == S_WAIT) begin
                if (bus_ack_i) begin
                    r_rdata <= bus_rdata_i;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_expire) begin
                        r_timeout <= 1'b1;
                    end
                end
            end
            // A timed-out access leaves the reservation untouched.
            if ((r_state == S_DONE) && !r_timeout) begin
                if (op_i == OP_LL) begin
                    r_llbit <= 1'b1;
                end else if (op_i == OP_SC) begin
                    r_llbit <= 1'b0;
                end
            end
        end
    end

    // Next state plus writeback/stall/exception outputs; reset forces every output low.
    always_comb begin
        w_next_state = r_state;
        we_o         = we_i;
        waddr_o      = waddr_i;
        wdata_o      = wdata_i;
        we_hilo_o    = we_hilo_i;
        hi_o         = hi_i;
        lo_o         = lo_i;
        stall_o      = 1'b0;
        excpt_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    if (w_misalign) begin
                        excpt_o = 1'b1;
                        we_o    = 1'b0;
                    end else if (w_sc_fail) begin
                        wdata_o = 32'd0;
                    end else begin
                        stall_o      = 1'b1;
                        we_o         = 1'b0;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                we_o    = 1'b0;
                if (bus_ack_i || w_expire) begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                if (r_timeout) begin
                    excpt_o = 1'b1;
                    we_o    = 1'b0;
                end else begin
                    case (op_i)
                        OP_LB:          wdata_o = {{24{w_byte[7]}}, w_byte};
                        OP_LBU:         wdata_o = {24'd0, w_byte};
                        OP_LW, OP_LL:   wdata_o = r_rdata;
                        OP_SC:          wdata_o = 32'd1;
                        default:        wdata_o = wdata_i;
                    endcase
                end
            end
        endcase
        if (rst) begin
            we_o      = 1'b0;
            waddr_o   = '0;
            wdata_o   = 32'd0;
            we_hilo_o = 1'b0;
            hi_o      = 32'd0;
            lo_o      = 32'd0;
            stall_o   = 1'b0;
            excpt_o   = 1'b0;
        end
    end

    assign bus_req_o   = !rst && (r_state == S_WAIT);
    assign bus_we_o    = rst ? 1'b0  : r_bus_we;
    assign bus_addr_o  = rst ? '0    : r_bus_addr;
    assign bus_be_o    = rst ? 4'd0  : r_bus_be;
    assign bus_wdata_o = rst ? 32'd0 : r_bus_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: reset, pass-through, byte loads, byte store, LL/SC, misalign, timeout, reset mid-wait.
// Latency: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: bus_ack_i is driven by the bench only where each scenario calls for it.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        we_hilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] sdata_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        we_hilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_o;
    logic        excpt_o;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .we_hilo_i(we_hilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .op_i(op_i), .addr_i(addr_i), .sdata_i(sdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .we_hilo_o(we_hilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stall_o(stall_o), .excpt_o(excpt_o)
    );

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we_i = 1'b1; waddr_i = 5'h1f; wdata_i = 32'hDEAD_BEEF;
        we_hilo_i = 1'b1; hi_i = 32'h1111_2222; lo_i = 32'h3333_4444;
        op_i = 3'd3; addr_i = 32'h100; sdata_i = 32'h5; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        adv(); adv();
        @(negedge clk);
        n_vec++; if (we_o !== 1'b0)      begin n_mis++; $display("FAIL rst_we_o got %0h want 0", we_o); end
        n_vec++; if (wdata_o !== 32'd0)  begin n_mis++; $display("FAIL rst_wdata_o got %0h want 0", wdata_o); end
        n_vec++; if (hi_o !== 32'd0)     begin n_mis++; $display("FAIL rst_hi_o got %0h want 0", hi_o); end
        n_vec++; if (stall_o !== 1'b0)   begin n_mis++; $display("FAIL rst_stall got %0h want 0", stall_o); end
        n_vec++; if (bus_req_o !== 1'b0) begin n_mis++; $display("FAIL rst_bus_req got %0h want 0", bus_req_o); end
        adv();
        rst = 1'b0; op_i = 3'd0;
    endtask

    task automatic test_passthru();
        op_i = 3'd0; we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hA5A5_0001;
        we_hilo_i = 1'b1; hi_i = 32'h0BAD_F00D; lo_i = 32'h1234_5678; bus_ack_i = 1'b1;
        @(negedge clk);
        n_vec++; if (wdata_o !== 32'hA5A5_0001) begin n_mis++; $display("FAIL pt_wdata got %0h want a5a50001", wdata_o); end
        n_vec++; if (waddr_o !== 5'd9)          begin n_mis++; $display("FAIL pt_waddr got %0h want 9", waddr_o); end
        n_vec++; if (lo_o !== 32'h1234_5678)    begin n_mis++; $display("FAIL pt_lo got %0h want 12345678", lo_o); end
        n_vec++; if (we_hilo_o !== 1'b1)        begin n_mis++; $display("FAIL pt_we_hilo got %0h want 1", we_hilo_o); end
        adv();
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0)
            begin n_mis++; $display("FAIL pt_ack_ignored got req=%0h stall=%0h want 0/0", bus_req_o, stall_o); end
        adv();
        bus_ack_i = 1'b0;
    endtask

    task automatic test_load_byte(input logic [2:0] op, input logic [31:0] exp);
        op_i = op; addr_i = 32'h1003; we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h55;
        @(negedge clk);
        n_vec++; if (stall_o !== 1'b1 || bus_req_o !== 1'b0)
            begin n_mis++; $display("FAIL lbx_idle op%0d got stall=%0h req=%0h want 1/0", op, stall_o, bus_req_o); end
        adv();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_56F0;
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b1 || stall_o !== 1'b1 || bus_we_o !== 1'b0)
            begin n_mis++; $display("FAIL lbx_wait op%0d got req=%0h stall=%0h we=%0h want 1/1/0", op, bus_req_o, stall_o, bus_we_o); end
        n_vec++; if (bus_addr_o !== 32'h1000 || bus_be_o !== 4'b1111)
            begin n_mis++; $display("FAIL lbx_bus op%0d got addr=%0h be=%0b want 1000/1111", op, bus_addr_o, bus_be_o); end
        adv();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        n_vec++; if (stall_o !== 1'b0 || we_o !== 1'b1 || bus_req_o !== 1'b0)
            begin n_mis++; $display("FAIL lbx_done_ctl op%0d got stall=%0h we=%0h req=%0h want 0/1/0", op, stall_o, we_o, bus_req_o); end
        n_vec++; if (wdata_o !== exp)
            begin n_mis++; $display("FAIL lbx_data op%0d got %0h want %0h", op, wdata_o, exp); end
        adv();
        op_i = 3'd0;
    endtask

    task automatic test_store_byte();
        op_i = 3'd4; addr_i = 32'h2001; sdata_i = 32'h1234_56AB; we_i = 1'b0; wdata_i = 32'h77;
        adv();
        bus_ack_i = 1'b1;
        @(negedge clk);
        n_vec++; if (bus_be_o !== 4'b0100)        begin n_mis++; $display("FAIL sb_be got %0b want 0100", bus_be_o); end
        n_vec++; if (bus_wdata_o !== 32'hABAB_ABAB) begin n_mis++; $display("FAIL sb_wdata got %0h want abababab", bus_wdata_o); end
        n_vec++; if (bus_we_o !== 1'b1 || bus_addr_o !== 32'h2000)
            begin n_mis++; $display("FAIL sb_we_addr got we=%0h addr=%0h want 1/2000", bus_we_o, bus_addr_o); end
        adv();
        bus_ack_i = 1'b0;
        @(negedge clk);
        n_vec++; if (wdata_o !== 32'h77 || we_o !== 1'b0 || stall_o !== 1'b0)
            begin n_mis++; $display("FAIL sb_done got wdata=%0h we=%0h stall=%0h want 77/0/0", wdata_o, we_o, stall_o); end
        adv();
        op_i = 3'd0;
    endtask

    task automatic test_ll_sc();
        op_i = 3'd6; addr_i = 32'h40; we_i = 1'b1; wdata_i = 32'h0;
        adv();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0000;
        adv();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        n_vec++; if (wdata_o !== 32'hCAFE_0000) begin n_mis++; $display("FAIL ll_data got %0h want cafe0000", wdata_o); end
        adv();
        op_i = 3'd7; sdata_i = 32'h1234; wdata_i = 32'h99;
        @(negedge clk);
        n_vec++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL sc1_stall got %0h want 1", stall_o); end
        adv();
        bus_ack_i = 1'b1;
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_wdata_o !== 32'h1234)
            begin n_mis++; $display("FAIL sc1_bus got req=%0h we=%0h wdata=%0h want 1/1/1234", bus_req_o, bus_we_o, bus_wdata_o); end
        adv();
        bus_ack_i = 1'b0;
        @(negedge clk);
        n_vec++; if (wdata_o !== 32'd1 || we_o !== 1'b1) begin n_mis++; $display("FAIL sc1_done got wdata=%0h we=%0h want 1/1", wdata_o, we_o); end
        adv();
        @(negedge clk);
        n_vec++; if (wdata_o !== 32'd0 || stall_o !== 1'b0 || bus_req_o !== 1'b0 || we_o !== 1'b1)
            begin n_mis++; $display("FAIL sc2_fail got wdata=%0h stall=%0h req=%0h we=%0h want 0/0/0/1", wdata_o, stall_o, bus_req_o, we_o); end
        adv();
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b0) begin n_mis++; $display("FAIL sc2_noreq got %0h want 0", bus_req_o); end
        adv();
        op_i = 3'd0;
    endtask

    task automatic test_misalign();
        op_i = 3'd3; addr_i = 32'h102; we_i = 1'b1;
        @(negedge clk);
        n_vec++; if (excpt_o !== 1'b1 || we_o !== 1'b0 || stall_o !== 1'b0 || bus_req_o !== 1'b0)
            begin n_mis++; $display("FAIL mis_ctl got ex=%0h we=%0h stall=%0h req=%0h want 1/0/0/0", excpt_o, we_o, stall_o, bus_req_o); end
        adv();
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b0) begin n_mis++; $display("FAIL mis_noreq got %0h want 0", bus_req_o); end
        adv();
        op_i = 3'd0;
        @(negedge clk);
        n_vec++; if (excpt_o !== 1'b0) begin n_mis++; $display("FAIL mis_clear got %0h want 0", excpt_o); end
        adv();
    endtask

    task automatic test_timeout();
        int n;
        op_i = 3'd3; addr_i = 32'h200; we_i = 1'b1; bus_ack_i = 1'b0;
        adv();
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus_req_o !== 1'b1) break;
            n++;
            adv();
        end
        n_vec++; if (n != 15) begin n_mis++; $display("FAIL to_req_cycles got %0d want 15", n); end
        n_vec++; if (excpt_o !== 1'b1 || we_o !== 1'b0 || stall_o !== 1'b0)
            begin n_mis++; $display("FAIL to_done got ex=%0h we=%0h stall=%0h want 1/0/0", excpt_o, we_o, stall_o); end
        adv();
        op_i = 3'd0;
        @(negedge clk);
        n_vec++; if (excpt_o !== 1'b0 || stall_o !== 1'b0 || we_o !== 1'b1)
            begin n_mis++; $display("FAIL to_idle got ex=%0h stall=%0h we=%0h want 0/0/1", excpt_o, stall_o, we_o); end
        adv();
    endtask

    task automatic test_reset_mid_wait();
        op_i = 3'd6; addr_i = 32'h300; we_i = 1'b1;
        adv();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1;
        adv();
        bus_ack_i = 1'b0;
        adv();
        op_i = 3'd3; addr_i = 32'h304;
        adv();
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b1) begin n_mis++; $display("FAIL rmw_inwait got %0h want 1", bus_req_o); end
        adv();
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || bus_be_o !== 4'd0)
            begin n_mis++; $display("FAIL rmw_rst_out got req=%0h stall=%0h be=%0b want 0/0/0", bus_req_o, stall_o, bus_be_o); end
        adv();
        rst = 1'b0; op_i = 3'd0; we_i = 1'b1; wdata_i = 32'd5;
        @(negedge clk);
        n_vec++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || we_o !== 1'b1 || wdata_o !== 32'd5)
            begin n_mis++; $display("FAIL rmw_after got req=%0h stall=%0h we=%0h wdata=%0h want 0/0/1/5", bus_req_o, stall_o, we_o, wdata_o); end
        adv();
        op_i = 3'd7; addr_i = 32'h300; wdata_i = 32'd7;
        @(negedge clk);
        n_vec++; if (wdata_o !== 32'd0 || stall_o !== 1'b0)
            begin n_mis++; $display("FAIL rmw_llbit got wdata=%0h stall=%0h want 0/0", wdata_o, stall_o); end
        adv();
        op_i = 3'd0;
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_load_byte(3'd1, 32'hFFFF_FFF0);
        test_load_byte(3'd2, 32'h0000_00F0);
        test_store_byte();
        test_ll_sc();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
